// File: rtl/bar_level_ctrl.sv
// Level-meter controller: 8-bit samples to a 0..10 bar code with timed decay, peak hold, lamp sweep and fault code.
// Latency: an accepted sample shows on level/peak one clock later; fault forces code 11 on the next clock.
// Backpressure: sample_ready is high only in RUN; samples offered during sweep or fault wait at the source.
module bar_level_ctrl #(
    parameter int CLK_DIV     = 50000,
    parameter int DECAY_TICKS = 50,
    parameter int HOLD_TICKS  = 500,
    parameter int SWEEP_TICKS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [7:0] sample,
    output logic       sample_ready,
    input  logic       lamp_test,
    input  logic       fault,
    output logic [3:0] level,
    output logic [3:0] peak,
    output logic       busy
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam int SW = (SWEEP_TICKS > 1) ? $clog2(SWEEP_TICKS) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [3:0] LVL_MAX   = 4'd10;
    localparam logic [3:0] LVL_FAULT = 4'd11;

    typedef enum logic [1:0] {
        RUN,
        SWEEP_UP,
        SWEEP_DOWN,
        FAULT
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [SW-1:0] scnt, scnt_n;
    logic [HW-1:0] hold, hold_n;
    logic [3:0]    target, target_n;
    logic [3:0]    level_n, peak_n;
    logic          sample_ready_n;
    logic          tick, dstb, sstep, accept;
    logic [3:0]    q;

    assign tick   = (presc == PW'(CLK_DIV - 1));
    assign dstb   = tick && (dcnt == DW'(DECAY_TICKS - 1));
    assign sstep  = tick && (scnt == SW'(SWEEP_TICKS - 1));
    assign accept = sample_valid && sample_ready;
    assign busy   = (state != RUN);

    // sample*11/256 maps 0..255 onto 0..10 without a divider
    assign q = 4'(({4'd0, sample} * 12'd11) >> 8);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_comb begin
        state_n  = state;
        level_n  = level;
        peak_n   = peak;
        target_n = target;
        hold_n   = hold;
        dcnt_n   = dcnt;
        scnt_n   = scnt;
        if (tick) begin
            dcnt_n = dstb ? '0 : dcnt + DW'(1);
            scnt_n = sstep ? '0 : scnt + SW'(1);
        end

        case (state)
            RUN: begin
                if (accept) begin
                    target_n = q;
                end
                if (accept && (q >= level)) begin
                    level_n = q;
                    dcnt_n  = '0;
                end else if (dstb && (level > target_n)) begin
                    level_n = level - 4'd1;
                end
                if (level_n > peak) begin
                    peak_n = level_n;
                    hold_n = HW'(HOLD_TICKS);
                end else begin
                    if (tick && (hold != '0)) begin
                        hold_n = hold - HW'(1);
                    end
                    // peak only falls once the hold window has fully expired
                    if ((hold == '0) && dstb && (peak > level_n)) begin
                        peak_n = peak - 4'd1;
                    end
                end
                if (lamp_test) begin
                    state_n = SWEEP_UP;
                    level_n = '0;
                    peak_n  = '0;
                    scnt_n  = '0;
                end
            end
            SWEEP_UP: begin
                if (sstep) begin
                    if (level >= LVL_MAX) begin
                        state_n = SWEEP_DOWN;
                        level_n = LVL_MAX - 4'd1;
                    end else begin
                        level_n = level + 4'd1;
                    end
                    peak_n = level_n;
                end
            end
            SWEEP_DOWN: begin
                if (sstep && (level != '0)) begin
                    level_n = level - 4'd1;
                    peak_n  = level_n;
                    if (level_n == '0) begin
                        state_n  = RUN;
                        target_n = '0;
                        hold_n   = '0;
                    end
                end
            end
            FAULT: begin
                level_n = LVL_FAULT;
                peak_n  = LVL_FAULT;
                if (!fault) begin
                    state_n  = RUN;
                    level_n  = '0;
                    peak_n   = '0;
                    target_n = '0;
                    hold_n   = '0;
                    dcnt_n   = '0;
                    scnt_n   = '0;
                end
            end
            default: begin
                state_n = RUN;
            end
        endcase

        if (fault) begin
            state_n = FAULT;
            level_n = LVL_FAULT;
            peak_n  = LVL_FAULT;
        end

        sample_ready_n = (state_n == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            level        <= '0;
            peak         <= '0;
            target       <= '0;
            hold         <= '0;
            dcnt         <= '0;
            scnt         <= '0;
            sample_ready <= 1'b0;
        end else begin
            state        <= state_n;
            level        <= level_n;
            peak         <= peak_n;
            target       <= target_n;
            hold         <= hold_n;
            dcnt         <= dcnt_n;
            scnt         <= scnt_n;
            sample_ready <= sample_ready_n;
        end
    end

endmodule

// File: tb/tb_bar_level_ctrl.sv
// Directed bench for bar_level_ctrl with small timing parameters (4 clk/tick, 8 clk/decay step).
module tb_bar_level_ctrl;

    logic       clk;
    logic       rst;
    logic       sample_valid;
    logic [7:0] sample;
    logic       sample_ready;
    logic       lamp_test;
    logic       fault;
    logic [3:0] level;
    logic [3:0] peak;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int ge_viol = 0;
    int eq_viol = 0;
    int range_viol = 0;
    int rdy_viol = 0;
    bit mon_ge = 0;
    bit mon_eq = 0;
    int c;
    int n;

    bar_level_ctrl #(
        .CLK_DIV    (4),
        .DECAY_TICKS(2),
        .HOLD_TICKS (3),
        .SWEEP_TICKS(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_valid(sample_valid),
        .sample      (sample),
        .sample_ready(sample_ready),
        .lamp_test   (lamp_test),
        .fault       (fault),
        .level       (level),
        .peak        (peak),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (mon_ge && (peak < level)) ge_viol++;
        if (mon_eq && (peak != level)) eq_viol++;
        if ((level > 4'd11) || (peak > 4'd11)) range_viol++;
    endtask

    task automatic wait_level_change(input int budget, output int cyc);
        logic [3:0] prev;
        prev = level;
        cyc  = 0;
        while ((level === prev) && (cyc < budget)) begin
            step();
            cyc++;
        end
    endtask

    task automatic wait_peak_change(input int budget, output int cyc);
        logic [3:0] prev;
        prev = peak;
        cyc  = 0;
        while ((peak === prev) && (cyc < budget)) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b1;
        sample_valid = 1'b0;
        sample = 8'd0;
        lamp_test = 1'b0;
        fault = 1'b0;

        // reset and idle
        step();
        step();
        chk("rst_level", 32'(level), 0);
        chk("rst_peak", 32'(peak), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        step();
        chk("idle_ready", 32'(sample_ready), 1);
        chk("idle_level", 32'(level), 0);
        chk("idle_busy", 32'(busy), 0);

        // full-scale attack then release to zero
        mon_ge = 1;
        sample_valid = 1'b1;
        sample = 8'd255;
        step();
        chk("atk255_level", 32'(level), 10);
        chk("atk255_peak", 32'(peak), 10);
        sample = 8'd0;
        step();
        sample_valid = 1'b0;
        chk("rel0_level_hold", 32'(level), 10);
        for (int e = 9; e >= 0; e--) begin
            wait_level_change(12, c);
            chk("decay_level", 32'(level), 32'(e));
            if (e < 9) chk("decay_interval", 32'(c), 8);
            if (e == 9) chk("peak_held", 32'(peak), 10);
            if (e == 8) chk("peak_first_decay", 32'(peak), 9);
            if (e == 0) chk("peak_at_level0", 32'(peak), 1);
        end
        wait_peak_change(12, c);
        chk("peak_final", 32'(peak), 0);
        chk("peak_final_interval", 32'(c), 8);

        // quantiser boundaries and a smaller sample under a higher level
        sample_valid = 1'b1;
        sample = 8'd23;
        step();
        chk("q23", 32'(level), 0);
        sample = 8'd24;
        step();
        chk("q24", 32'(level), 1);
        sample = 8'd128;
        step();
        chk("q128", 32'(level), 5);
        chk("q128_peak", 32'(peak), 5);
        sample = 8'd100;
        step();
        sample_valid = 1'b0;
        chk("q100_hold", 32'(level), 5);
        wait_level_change(12, c);
        chk("q100_decay", 32'(level), 4);
        repeat (24) step();
        chk("q100_floor", 32'(level), 4);
        chk("q100_peak_settle", 32'(peak), 4);

        // lamp-test sweep
        lamp_test = 1'b1;
        step();
        lamp_test = 1'b0;
        chk("sweep_busy", 32'(busy), 1);
        chk("sweep_ready", 32'(sample_ready), 0);
        chk("sweep_start_level", 32'(level), 0);
        chk("sweep_start_peak", 32'(peak), 0);
        mon_eq = 1;
        for (int i = 1; i <= 20; i++) begin
            wait_level_change(8, c);
            chk("sweep_level", 32'(level), (i <= 10) ? 32'(i) : 32'(20 - i));
            if (i > 1) chk("sweep_interval", 32'(c), 4);
        end
        chk("sweep_end_busy", 32'(busy), 0);
        chk("sweep_end_ready", 32'(sample_ready), 1);
        mon_eq = 0;
        chk("sweep_peak_eq_level", 32'(eq_viol), 0);

        // asynchronous reset in the middle of a sweep
        lamp_test = 1'b1;
        step();
        lamp_test = 1'b0;
        n = 0;
        while ((level !== 4'd3) && (n < 40)) begin
            step();
            n++;
        end
        chk("sweep_reach3", 32'(level), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_level", 32'(level), 0);
        chk("arst_peak", 32'(peak), 0);
        chk("arst_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("arst_release_ready", 32'(sample_ready), 1);

        // fault during SWEEP_UP, samples ignored
        lamp_test = 1'b1;
        step();
        lamp_test = 1'b0;
        n = 0;
        while ((level !== 4'd2) && (n < 20)) begin
            step();
            n++;
        end
        chk("fault_pre_level", 32'(level), 2);
        fault = 1'b1;
        sample_valid = 1'b1;
        sample = 8'd255;
        step();
        chk("fault_level", 32'(level), 11);
        chk("fault_peak", 32'(peak), 11);
        chk("fault_busy", 32'(busy), 1);
        chk("fault_ready", 32'(sample_ready), 0);
        repeat (10) step();
        chk("fault_level_held", 32'(level), 11);
        chk("fault_peak_held", 32'(peak), 11);
        sample_valid = 1'b0;
        fault = 1'b0;
        step();
        chk("unfault_level", 32'(level), 0);
        chk("unfault_peak", 32'(peak), 0);
        chk("unfault_busy", 32'(busy), 0);
        chk("unfault_ready", 32'(sample_ready), 1);
        step();
        chk("unfault_level_stay", 32'(level), 0);

        // sample held valid through a sweep, taken on first RUN cycle
        sample_valid = 1'b1;
        sample = 8'd200;
        lamp_test = 1'b1;
        step();
        lamp_test = 1'b0;
        chk("hold_sweep_busy", 32'(busy), 1);
        chk("hold_sweep_level", 32'(level), 0);
        n = 0;
        while ((busy === 1'b1) && (n < 100)) begin
            if (sample_ready !== 1'b0) rdy_viol++;
            step();
            n++;
        end
        chk("hold_sweep_never_ready", 32'(rdy_viol), 0);
        chk("hold_sweep_done", 32'(busy), 0);
        chk("hold_sweep_end_level", 32'(level), 0);
        step();
        sample_valid = 1'b0;
        chk("hold_accept_level", 32'(level), 8);
        chk("hold_accept_peak", 32'(peak), 8);

        chk("peak_ge_level", 32'(ge_viol), 0);
        chk("code_range", 32'(range_viol), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
